// File: rtl/flash_bus_arbiter.sv
// Shares one flash pin set between an SPI master and a QSPI controller with
// round-robin ownership and dead guard cycles between owners. FLASH_ARB_TIMEOUT_EN adds an idle-hold timeout.
module flash_bus_arbiter #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iSPI_REQ,
    output logic       oSPI_GNT,
    input  logic       iSPI_SCK,
    input  logic       iSPI_MOSI,
    input  logic       iSPI_CSn,
    input  logic       iQSPI_REQ,
    output logic       oQSPI_GNT,
    input  logic       iQSPI_SCK,
    input  logic       iQSPI_CSn,
    input  logic [3:0] iQSPI_DOUT,
    input  logic [3:0] iQSPI_DOE,
    output logic       oFLASH_SCK,
    output logic       oFLASH_CSn,
    output logic [3:0] oFLASH_DOUT,
    output logic [3:0] oFLASH_DOE,
    output logic       oBUSY,
    output logic       oTIMEOUT
);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
        $error("GUARD_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_GUARD, ST_GRANT_SPI, ST_GRANT_QSPI, ST_DRAIN
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_owner, w_owner_nxt;        // 1 = QSPI
    logic       r_pend, w_pend_nxt;
    logic       r_last_qspi, w_last_nxt;

    logic w_own_req, w_own_csn, w_oth_req, w_granted, w_to_fire, w_pick_qspi;

    assign w_own_req = r_owner ? iQSPI_REQ : iSPI_REQ;
    assign w_own_csn = r_owner ? iQSPI_CSn : iSPI_CSn;
    assign w_oth_req = r_owner ? iSPI_REQ  : iQSPI_REQ;
    assign w_granted = (r_state == ST_GRANT_SPI) || (r_state == ST_GRANT_QSPI);
    // QSPI wins when alone, or when both ask and SPI was served last.
    assign w_pick_qspi = iQSPI_REQ & (~iSPI_REQ | ~r_last_qspi);

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_timeout;
    logic        w_to_qual;

    assign w_to_qual = w_granted && w_own_req && w_own_csn && w_oth_req;
    assign w_to_fire = w_to_qual && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign oTIMEOUT  = r_timeout;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            r_to_cnt  <= (w_to_qual && !w_to_fire) ? r_to_cnt + 16'd1 : 16'd0;
        end
    end
`else
    assign w_to_fire = 1'b0;
    assign oTIMEOUT  = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_pend      <= 1'b0;
            r_last_qspi <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_pend      <= w_pend_nxt;
            r_last_qspi <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_pend_nxt  = r_pend;
        w_last_nxt  = r_last_qspi;
        case (r_state)
            ST_IDLE: begin
                if (iSPI_REQ || iQSPI_REQ) begin
                    w_owner_nxt = w_pick_qspi;
                    w_last_nxt  = w_pick_qspi;
                    w_pend_nxt  = 1'b1;
                    w_cnt_nxt   = 8'(GUARD_CYCLES);
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (r_cnt == 8'd0) begin
                    w_pend_nxt = 1'b0;
                    if (!r_pend)      w_state_nxt = ST_IDLE;
                    else if (r_owner) w_state_nxt = ST_GRANT_QSPI;
                    else              w_state_nxt = ST_GRANT_SPI;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_GRANT_SPI, ST_GRANT_QSPI: begin
                if (!w_own_req) begin
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = 8'(GUARD_CYCLES);
                    w_state_nxt = w_own_csn ? ST_GUARD : ST_DRAIN;
                end else if (w_to_fire) begin
                    w_owner_nxt = ~r_owner;
                    w_last_nxt  = ~r_owner;
                    w_pend_nxt  = 1'b1;
                    w_cnt_nxt   = 8'(GUARD_CYCLES);
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_DRAIN: begin
                // Owner finishes its transaction before the bus is released.
                if (w_own_csn) begin
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = 8'(GUARD_CYCLES);
                    w_state_nxt = ST_GUARD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign oSPI_GNT  = (r_state == ST_GRANT_SPI);
    assign oQSPI_GNT = (r_state == ST_GRANT_QSPI);
    assign oBUSY     = (r_state != ST_IDLE);

    always_comb begin
        oFLASH_SCK  = 1'b0;
        oFLASH_CSn  = 1'b1;
        oFLASH_DOUT = 4'b0000;
        oFLASH_DOE  = 4'b0000;
        if (w_granted || r_state == ST_DRAIN) begin
            if (r_owner) begin
                oFLASH_SCK  = iQSPI_SCK;
                oFLASH_CSn  = iQSPI_CSn;
                oFLASH_DOUT = iQSPI_DOUT;
                oFLASH_DOE  = iQSPI_DOE;
            end else begin
                oFLASH_SCK  = iSPI_SCK;
                oFLASH_CSn  = iSPI_CSn;
                oFLASH_DOUT = {3'b110, iSPI_MOSI};
                oFLASH_DOE  = 4'b1101;
            end
        end
    end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Randomized and directed bench for flash_bus_arbiter against a timeline-based reference model.
module tb_flash_bus_arbiter;
    localparam int G = 4;
    localparam int T = 16;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, spi_req, spi_sck, spi_mosi, spi_csn;
    logic       q_req, q_sck, q_csn;
    logic [3:0] q_dout, q_doe;
    logic       spi_gnt, q_gnt, f_sck, f_csn, busy, tmo;
    logic [3:0] f_dout, f_doe;

    flash_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .iCLK(clk), .iRESET(rst),
        .iSPI_REQ(spi_req), .oSPI_GNT(spi_gnt),
        .iSPI_SCK(spi_sck), .iSPI_MOSI(spi_mosi), .iSPI_CSn(spi_csn),
        .iQSPI_REQ(q_req), .oQSPI_GNT(q_gnt),
        .iQSPI_SCK(q_sck), .iQSPI_CSn(q_csn), .iQSPI_DOUT(q_dout), .iQSPI_DOE(q_doe),
        .oFLASH_SCK(f_sck), .oFLASH_CSn(f_csn), .oFLASH_DOUT(f_dout), .oFLASH_DOE(f_doe),
        .oBUSY(busy), .oTIMEOUT(tmo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: owner 0 = none, 1 = SPI, 2 = QSPI. A session starts when a request
    // is accepted; the bus goes to the owner G+1 edges later.
    int cyc = 0;
    bit m_active, m_held, m_drain, m_to;
    int m_owner, m_last, m_grant_at, m_tocnt;

    task automatic model_edge();
        bit own_req, own_cs, oth_req;
        cyc++;
        m_to    = 1'b0;
        own_req = (m_owner == 2) ? q_req : spi_req;
        own_cs  = (m_owner == 2) ? q_csn : spi_csn;
        oth_req = (m_owner == 2) ? spi_req : q_req;
        if (rst) begin
            m_active = 0; m_held = 0; m_drain = 0; m_owner = 0; m_last = 2; m_tocnt = 0;
        end else if (!m_active) begin
            if (spi_req || q_req) begin
                m_owner    = (spi_req && q_req) ? ((m_last == 1) ? 2 : 1) : (spi_req ? 1 : 2);
                m_last     = m_owner;
                m_active   = 1;
                m_grant_at = cyc + G + 1;
            end
        end else if (m_held) begin
            if (!own_req) begin
                m_held = 0; m_tocnt = 0;
                if (own_cs) begin m_owner = 0; m_grant_at = cyc + G + 1; end
                else m_drain = 1;
            end else if (TO_EN && own_cs && oth_req) begin
                m_tocnt++;
                if (m_tocnt == T) begin
                    m_to = 1; m_tocnt = 0; m_held = 0;
                    m_owner = 3 - m_owner; m_last = m_owner;
                    m_grant_at = cyc + G + 1;
                end
            end else m_tocnt = 0;
        end else if (m_drain) begin
            if (own_cs) begin m_drain = 0; m_owner = 0; m_grant_at = cyc + G + 1; end
        end else if (cyc == m_grant_at) begin
            if (m_owner != 0) m_held = 1;
            else m_active = 0;
        end
    endtask

    task automatic model_check();
        logic [9:0] exp_pins;
        exp_pins = {1'b0, 1'b1, 4'b0000, 4'b0000};
        if (m_held || m_drain) begin
            if (m_owner == 2) exp_pins = {q_sck, q_csn, q_dout, q_doe};
            else              exp_pins = {spi_sck, spi_csn, 3'b110, spi_mosi, 4'b1101};
        end
        chk("gnt",  32'({spi_gnt, q_gnt}), 32'({m_held && m_owner == 1, m_held && m_owner == 2}));
        chk("pins", 32'({f_sck, f_csn, f_dout, f_doe}), 32'(exp_pins));
        chk("busy", 32'(busy), 32'(m_active));
        chk("tmo",  32'(tmo), 32'(m_to));
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_gnt(input int maxc);
        int n;
        n = 0;
        while (!(spi_gnt || q_gnt) && n < maxc) begin tick(); n++; end
        if (!(spi_gnt || q_gnt)) chk("gnt_wait_expired", 32'(0), 32'(1));
    endtask

    task automatic rand_pins();
        spi_sck = 1'($urandom); spi_mosi = 1'($urandom);
        q_sck = 1'($urandom); q_dout = 4'($urandom); q_doe = 4'($urandom);
    endtask

    initial begin
        int n, pulses, pulse_at;
        rst = 1; spi_req = 0; spi_sck = 0; spi_mosi = 0; spi_csn = 1;
        q_req = 0; q_sck = 0; q_csn = 1; q_dout = 0; q_doe = 0;
        m_to = 0;
        @(posedge clk); model_edge(); #1;
        tick(); tick();
        chk("rst_gnt",  32'({spi_gnt, q_gnt}), 32'(0));
        chk("rst_busy", 32'({busy, tmo}), 32'(0));
        chk("rst_pins", 32'({f_sck, f_csn, f_dout, f_doe}), 32'(10'b0100000000));
        rst = 0;

        // Grant latency and SPI pin mapping
        spi_req = 1;
        repeat (G + 1) tick();
        chk("lat_pre", 32'(spi_gnt), 32'(0));
        tick();
        chk("lat_gnt",   32'(spi_gnt), 32'(1));
        chk("spi_doe",   32'(f_doe), 32'(4'b1101));
        chk("spi_dout3", 32'(f_dout[3:2]), 32'(2'b11));
        spi_csn = 0;
        repeat (5) begin rand_pins(); tick(); end
        spi_csn = 1; spi_req = 0;
        repeat (8) tick();

        // Round robin after reset
        rst = 1; tick(); rst = 0;
        spi_req = 1; q_req = 1;
        wait_gnt(20);
        chk("rr_first", 32'({spi_gnt, q_gnt}), 32'(2'b10));
        spi_req = 0; tick(); spi_req = 1;
        wait_gnt(20);
        chk("rr_second", 32'({spi_gnt, q_gnt}), 32'(2'b01));

        // QSPI drain with CSn low, then guard
        spi_req = 0; q_csn = 0;
        repeat (3) begin rand_pins(); tick(); end
        q_req = 0;
        repeat (7) begin rand_pins(); tick(); end
        chk("drain_gnt",  32'(q_gnt), 32'(0));
        chk("drain_busy", 32'(busy), 32'(1));
        chk("drain_doe",  32'(f_doe), 32'(q_doe));
        q_csn = 1; tick();
        n = 0;
        while (busy && n < 20) begin
            chk("guard_doe", 32'(f_doe), 32'(0));
            tick(); n++;
        end
        chk("guard_len", 32'(n), 32'(G + 1));

        // Reset in the middle of a QSPI transfer
        q_req = 1;
        wait_gnt(20);
        chk("q_gnt", 32'(q_gnt), 32'(1));
        q_csn = 0; q_doe = 4'hF; tick(); tick();
        rst = 1; tick();
        chk("mid_rst", 32'({f_csn, f_doe, q_gnt, spi_gnt, busy}), 32'(8'b1_0000_000));
        rst = 0; q_req = 0; q_csn = 1; repeat (3) tick();

        // Idle hold by SPI while QSPI waits
        spi_req = 1; spi_csn = 1;
        wait_gnt(20);
        q_req = 1;
        pulses = 0; pulse_at = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tmo) begin pulses++; pulse_at = k; end
        end
        if (TO_EN) begin
            chk("to_pulses", 32'(pulses), 32'(1));
            chk("to_cycle",  32'(pulse_at), 32'(T));
            chk("to_q_gnt",  32'(q_gnt), 32'(1));
        end else begin
            chk("to_none",   32'(pulses), 32'(0));
            chk("spi_keeps", 32'(spi_gnt), 32'(1));
        end
        spi_req = 0; q_req = 0; q_csn = 1;
        repeat (2 * G + 6) tick();

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(7) == 0) spi_req = ~spi_req;
            if ($urandom_range(7) == 0) q_req = ~q_req;
            if ($urandom_range(3) == 0) spi_csn = ~spi_csn;
            if ($urandom_range(3) == 0) q_csn = ~q_csn;
            rand_pins();
            rst = ($urandom_range(299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
